sram_port_arbiter: RTL and testbench

- Shares one single-port DFFRAM macro (byte write enables, 1-cycle registered read) between two requesters.
- Port 0 is the ICCM programming path (controller loading code from UART). Port 1 is the TL-UL memory adapter path (core fetch/LSU).
- Arbitration is fixed priority with a starvation guard and a programming lock.
- Every accepted access gets a one-cycle-later response per port.

---
 rtl/sram_port_arbiter_pkg.sv | 23 ++
 rtl/sram_rsp_pipe.sv | 58 +++++
 rtl/sram_port_arbiter.sv | 122 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// rtl/sram_port_arbiter_pkg.sv - shared types and port indices for the SRAM port arbiter
package sram_port_arbiter_pkg;

    localparam int SRAM_AW = 10;
    localparam int SRAM_DW = 32;
    localparam int SRAM_BW = SRAM_DW / 8;

    localparam logic PortProg = 1'b0;
    localparam logic PortBus  = 1'b1;

    typedef struct packed {
        logic               we;
        logic [SRAM_BW-1:0] be;
        logic [SRAM_AW-1:0] addr;
        logic [SRAM_DW-1:0] wdata;
    } sram_req_t;

    typedef struct packed {
        logic               rvalid;
        logic [SRAM_DW-1:0] rdata;
    } sram_rsp_t;

endpackage

// File: rtl/sram_rsp_pipe.sv
// rtl/sram_rsp_pipe.sv - single-stage response register routing rvalid/rdata to the issuing port
module sram_rsp_pipe
    import sram_port_arbiter_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               accept_i,
    input  logic               port_i,
    input  logic               is_write_i,
    input  logic [SRAM_DW-1:0] mem_rdata_i,
    output sram_rsp_t          rsp0_o,
    output sram_rsp_t          rsp1_o
);

    logic valid_q, valid_d;
    logic port_q, port_d;
    logic wr_q, wr_d;
    logic [SRAM_DW-1:0] rsp_data;

    always_comb begin
        valid_d = accept_i;
        port_d  = port_q;
        wr_d    = wr_q;
        if (accept_i) begin
            port_d = port_i;
            wr_d   = is_write_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            port_q  <= PortProg;
            wr_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            port_q  <= port_d;
            wr_q    <= wr_d;
        end
    end

    // Write acks carry zero data; the macro output is only meaningful after a read.
    always_comb begin
        rsp0_o   = '0;
        rsp1_o   = '0;
        rsp_data = (valid_q && !wr_q) ? mem_rdata_i : '0;
        if (valid_q) begin
            if (port_q == PortBus) begin
                rsp1_o.rvalid = 1'b1;
                rsp1_o.rdata  = rsp_data;
            end else begin
                rsp0_o.rvalid = 1'b1;
                rsp0_o.rdata  = rsp_data;
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-port fixed-priority arbiter with starvation guard for one DFFRAM macro
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int AW         = SRAM_AW,
    parameter int DW         = SRAM_DW,
    parameter int StallLimit = 4,
    parameter int CntW       = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            prio_lock_i,
    input  logic            p0_req_i,
    input  logic            p0_we_i,
    input  logic [DW/8-1:0] p0_be_i,
    input  logic [AW-1:0]   p0_addr_i,
    input  logic [DW-1:0]   p0_wdata_i,
    output logic            p0_gnt_o,
    output logic            p0_rvalid_o,
    output logic [DW-1:0]   p0_rdata_o,
    input  logic            p1_req_i,
    input  logic            p1_we_i,
    input  logic [DW/8-1:0] p1_be_i,
    input  logic [AW-1:0]   p1_addr_i,
    input  logic [DW-1:0]   p1_wdata_i,
    output logic            p1_gnt_o,
    output logic            p1_rvalid_o,
    output logic [DW-1:0]   p1_rdata_o,
    output logic            mem_en_o,
    output logic [DW/8-1:0] mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    input  logic [DW-1:0]   mem_rdata_i,
    output logic [CntW-1:0] conflict_cnt_o
);

    localparam logic [3:0] STALL_LIM = 4'(StallLimit);

    logic [3:0]      stall_q, stall_d;
    logic [CntW-1:0] conflict_q, conflict_d;
    logic            gnt0, gnt1;
    sram_req_t       p0_req, p1_req, sel;
    sram_rsp_t       rsp0, rsp1;

    assign p0_req = '{we: p0_we_i, be: p0_be_i, addr: p0_addr_i, wdata: p0_wdata_i};
    assign p1_req = '{we: p1_we_i, be: p1_be_i, addr: p1_addr_i, wdata: p1_wdata_i};

    // Grants are forced low while reset is asserted so the macro sees no access.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_i) begin
            gnt0 = 1'b0;
        end else if (prio_lock_i) begin
            gnt0 = p0_req_i;
        end else if (p0_req_i && p1_req_i) begin
            if (stall_q >= STALL_LIM) begin
                gnt1 = 1'b1;
            end else begin
                gnt0 = 1'b1;
            end
        end else begin
            gnt0 = p0_req_i;
            gnt1 = p1_req_i;
        end
    end

    always_comb begin
        sel = '0;
        if (gnt1) begin
            sel = p1_req;
        end else if (gnt0) begin
            sel = p0_req;
        end
        mem_en_o    = gnt0 | gnt1;
        mem_addr_o  = sel.addr;
        mem_wdata_o = sel.wdata;
        mem_we_o    = sel.we ? sel.be : '0;
    end

    // Stall count keeps running under lock so the bus side wins right after release.
    always_comb begin
        stall_d = 4'd0;
        if (p1_req_i && !gnt1) begin
            stall_d = (stall_q == 4'hF) ? stall_q : stall_q + 4'd1;
        end
        conflict_d = conflict_q;
        if (p0_req_i && p1_req_i && (conflict_q != {CntW{1'b1}})) begin
            conflict_d = conflict_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q    <= 4'd0;
            conflict_q <= '0;
        end else begin
            stall_q    <= stall_d;
            conflict_q <= conflict_d;
        end
    end

    sram_rsp_pipe u_rsp_pipe (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .accept_i   (mem_en_o),
        .port_i     (gnt1 ? PortBus : PortProg),
        .is_write_i (sel.we),
        .mem_rdata_i(mem_rdata_i),
        .rsp0_o     (rsp0),
        .rsp1_o     (rsp1)
    );

    assign p0_gnt_o       = gnt0;
    assign p1_gnt_o       = gnt1;
    assign p0_rvalid_o    = rsp0.rvalid;
    assign p0_rdata_o     = rsp0.rdata;
    assign p1_rvalid_o    = rsp1.rvalid;
    assign p1_rdata_o     = rsp1.rdata;
    assign conflict_cnt_o = conflict_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench with behavioural arbiter/memory model
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        prio_lock_i = 1'b0;
    logic        p0_req_i = 1'b0, p0_we_i = 1'b0;
    logic [3:0]  p0_be_i = 4'h0;
    logic [9:0]  p0_addr_i = 10'h0;
    logic [31:0] p0_wdata_i = 32'h0;
    logic        p1_req_i = 1'b0, p1_we_i = 1'b0;
    logic [3:0]  p1_be_i = 4'h0;
    logic [9:0]  p1_addr_i = 10'h0;
    logic [31:0] p1_wdata_i = 32'h0;
    logic        p0_gnt_o, p0_rvalid_o, p1_gnt_o, p1_rvalid_o, mem_en_o;
    logic [31:0] p0_rdata_o, p1_rdata_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [15:0] conflict_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(.AW(10), .DW(32), .StallLimit(4), .CntW(16)) dut (
        .clk_i(clk), .rst_i(rst_i), .prio_lock_i(prio_lock_i),
        .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_be_i(p0_be_i), .p0_addr_i(p0_addr_i),
        .p0_wdata_i(p0_wdata_i), .p0_gnt_o(p0_gnt_o), .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
        .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_be_i(p1_be_i), .p1_addr_i(p1_addr_i),
        .p1_wdata_i(p1_wdata_i), .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .conflict_cnt_o(conflict_cnt_o)
    );

    // Behavioural DFFRAM macro: byte writes, registered read.
    logic [31:0] macro_mem [0:1023];
    logic [31:0] macro_rd = 32'h0;
    assign mem_rdata_i = macro_rd;
    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o == 4'h0) macro_rd <= macro_mem[mem_addr_o];
            for (int b = 0; b < 4; b++)
                if (mem_we_o[b]) macro_mem[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: arbitration rules, pending response and expected memory contents.
    logic [31:0] ref_mem [0:1023];
    int          m_stall = 0;
    int          m_conf  = 0;
    bit          pend_v = 0, pend_port = 0;
    logic [31:0] pend_data = 32'h0;

    always @(negedge clk) begin
        bit          g0, g1;
        logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;
        logic [3:0]  e_we;
        g0 = 0; g1 = 0;
        if (rst_i) begin
            m_stall = 0; m_conf = 0; pend_v = 0;
        end else if (prio_lock_i) begin
            g0 = p0_req_i;
        end else if (p0_req_i && p1_req_i) begin
            if (m_stall >= 4) g1 = 1; else g0 = 1;
        end else begin
            g0 = p0_req_i; g1 = p1_req_i;
        end
        e_addr  = g1 ? 32'(p1_addr_i)  : g0 ? 32'(p0_addr_i)  : 32'h0;
        e_wdata = g1 ? p1_wdata_i : g0 ? p0_wdata_i : 32'h0;
        e_we    = g1 ? (p1_we_i ? p1_be_i : 4'h0) : g0 ? (p0_we_i ? p0_be_i : 4'h0) : 4'h0;
        e_rd0   = (pend_v && !pend_port) ? pend_data : 32'h0;
        e_rd1   = (pend_v && pend_port)  ? pend_data : 32'h0;
        chk("p0_gnt", p0_gnt_o, g0);
        chk("p1_gnt", p1_gnt_o, g1);
        chk("mem_en", mem_en_o, g0 | g1);
        chk("mem_addr", mem_addr_o, e_addr);
        chk("mem_wdata", mem_wdata_o, e_wdata);
        chk("mem_we", mem_we_o, e_we);
        chk("p0_rvalid", p0_rvalid_o, pend_v && !pend_port);
        chk("p1_rvalid", p1_rvalid_o, pend_v && pend_port);
        chk("p0_rdata", p0_rdata_o, e_rd0);
        chk("p1_rdata", p1_rdata_o, e_rd1);
        chk("conflict_cnt", conflict_cnt_o, m_conf);
        if (!rst_i) begin
            pend_v    = g0 | g1;
            pend_port = g1;
            if (g0 | g1) begin
                bit          we;
                logic [3:0]  be;
                logic [9:0]  a;
                logic [31:0] wd;
                we = g1 ? p1_we_i : p0_we_i;
                be = g1 ? p1_be_i : p0_be_i;
                a  = g1 ? p1_addr_i : p0_addr_i;
                wd = g1 ? p1_wdata_i : p0_wdata_i;
                pend_data = we ? 32'h0 : ref_mem[a];
                if (we)
                    for (int b = 0; b < 4; b++)
                        if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
            end
            m_stall = (p1_req_i && !g1) ? ((m_stall < 15) ? m_stall + 1 : 15) : 0;
            if (p0_req_i && p1_req_i && m_conf < 65535) m_conf++;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 rst_i = 1'b1;
        @(posedge clk); #1 rst_i = 1'b0;
    endtask

    // Issues one access, waits for its grant, returns one time unit after the accepting edge.
    task automatic access(input bit port, input bit we, input logic [3:0] be,
                          input logic [9:0] addr, input logic [31:0] wd);
        bit ok;
        @(posedge clk); #1;
        if (port) begin
            p1_req_i = 1; p1_we_i = we; p1_be_i = be; p1_addr_i = addr; p1_wdata_i = wd;
        end else begin
            p0_req_i = 1; p0_we_i = we; p0_be_i = be; p0_addr_i = addr; p0_wdata_i = wd;
        end
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = port ? p1_gnt_o : p0_gnt_o;
            @(posedge clk); #1;
        end
        if (port) p1_req_i = 0; else p0_req_i = 0;
        if (!ok) chk("grant_timeout", 0, 1);
    endtask

    task automatic expect_rsp(input string name, input bit port, input logic [31:0] exp);
        @(negedge clk);
        chk({name, "_rvalid"}, port ? p1_rvalid_o : p0_rvalid_o, 1);
        chk({name, "_rdata"}, port ? p1_rdata_o : p0_rdata_o, exp);
    endtask

    initial begin
        int n0, n1;
        logic [9:0] seq;
        for (int i = 0; i < 1024; i++) begin
            macro_mem[i] = 32'h0;
            ref_mem[i]   = 32'h0;
        end
        @(negedge clk);
        chk("reset_gnt", {p0_gnt_o, p1_gnt_o, mem_en_o}, 0);
        chk("reset_conflict", conflict_cnt_o, 0);
        @(posedge clk); #1 rst_i = 1'b0;

        // Read accepted, then reset asserted before the response edge completes.
        access(1, 0, 4'h0, 10'h3, 32'h0);
        rst_i = 1'b1;
        @(negedge clk);
        chk("rst_mid_read_rvalid", p1_rvalid_o, 0);
        @(posedge clk); #1 rst_i = 1'b0;
        @(negedge clk);
        chk("post_rst_rvalid", p1_rvalid_o, 0);
        chk("post_rst_mem", {mem_en_o, mem_we_o, 22'(mem_addr_o), mem_wdata_o}, 0);

        access(1, 1, 4'hF, 10'h10, 32'hDEADBEEF);
        expect_rsp("wr_ack", 1, 32'h0);
        access(1, 0, 4'h0, 10'h10, 32'h0);
        expect_rsp("rd_deadbeef", 1, 32'hDEADBEEF);

        access(0, 1, 4'hF, 10'h20, 32'h11223344);
        expect_rsp("bw_ack0", 0, 32'h0);
        access(0, 1, 4'b0101, 10'h20, 32'hAABBCCDD);
        expect_rsp("bw_ack1", 0, 32'h0);
        access(1, 1, 4'h0, 10'h20, 32'hFFFFFFFF);
        expect_rsp("be0_ack", 1, 32'h0);
        access(0, 0, 4'h0, 10'h20, 32'h0);
        expect_rsp("rd_bytes", 0, 32'h11BB33DD);

        // Back-to-back writes on p0 then alternating single-port reads.
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            p0_req_i = 1; p0_we_i = 1; p0_be_i = 4'hF;
            p0_addr_i = 10'(10'h40 + i); p0_wdata_i = 32'h01010101 * (i + 1);
            @(posedge clk); #1;
        end
        p0_req_i = 0;
        for (int i = 0; i < 6; i++) begin
            p0_req_i = (i % 2 == 0); p0_we_i = 0; p0_addr_i = 10'(10'h40 + i);
            p1_req_i = (i % 2 == 1); p1_we_i = 0; p1_addr_i = 10'(10'h40 + i);
            @(posedge clk); #1;
        end
        p0_req_i = 0; p1_req_i = 0;
        @(negedge clk);
        chk("alt_last_rdata", p1_rdata_o, 32'h0);

        // Lock: both request for 10 cycles, p1 must wait; then starvation pattern.
        do_reset();
        prio_lock_i = 1;
        p0_req_i = 1; p0_we_i = 0; p0_addr_i = 10'h10;
        p1_req_i = 1; p1_we_i = 0; p1_addr_i = 10'h20;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n0 += int'(p0_gnt_o); n1 += int'(p1_gnt_o);
            @(posedge clk); #1;
        end
        chk("lock_p0_grants", n0, 10);
        chk("lock_p1_grants", n1, 0);
        prio_lock_i = 0;
        @(negedge clk);
        chk("release_p1_gnt", p1_gnt_o, 1);
        chk("lock_conflicts", conflict_cnt_o, 16'd10);
        @(posedge clk); #1;
        seq = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seq[i] = p1_gnt_o;
            @(posedge clk); #1;
        end
        chk("starve_pattern", seq, 10'h210);
        p0_req_i = 0; p1_req_i = 0;
        @(negedge clk);
        chk("starve_final_rsp", {p1_rvalid_o, p1_rdata_o}, {1'b1, 32'h11BB33DD});
        @(posedge clk); #1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
